mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory stage of the SLC-3 datapath, directly downstream of the effective-address adder.
- Takes the computed 16-bit address into MAR, runs one SRAM read or write through a wait-state FSM, and returns read data through MDR.
- Gives the control FSM a valid/ready request handshake and a one-cycle done pulse.

Parameters:
- WAIT_STATES, 2: SRAM access cycles inserted between address setup and data transfer; legal range 0..15.
- ADDR_W, 16: address width.
- DATA_W, 16: data width.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  control requests an access.
- req_write  in  1  1 = write, 0 = read; sampled with req_valid.
- addr_in  in  ADDR_W  effective address from the address adder.
- wdata_in  in  DATA_W  write data from the bus.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- done  out  1  one-cycle pulse when the access completes.
- MAR_out  out  ADDR_W  current MAR contents.
- MDR_out  out  DATA_W  current MDR contents (read result or write data).
- MEM_ADDR  out  ADDR_W  SRAM address; equals MAR.
- Data_to_SRAM  out  DATA_W  SRAM write data; equals MDR.
- Data_from_SRAM  in  DATA_W  SRAM read data.
- MEM_CE_n, MEM_OE_n, MEM_WE_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Reset (async, Reset_n=0):
  - State goes to IDLE; MAR=0, MDR=0, wait counter=0, latched write flag=0.
  - done=0, req_ready=1 once in IDLE, all three strobes=1.
  - Reset mid-access aborts immediately; strobes deassert asynchronously. No partial MDR update.
- IDLE:
  - req_ready=1; strobes high.
  - Accept when req_valid & req_ready (call this cycle 0):
    - MAR<=addr_in; latched write flag<=req_write.
    - If write: MDR<=wdata_in. If read: MDR holds its value.
    - Go to ADDR.
- ADDR (cycle 1):
  - MEM_CE_n=0; MEM_OE_n=0 for reads; MEM_WE_n=1 for both (address setup).
  - cnt<=WAIT_STATES-1.
  - Next state is WAIT if WAIT_STATES>0, otherwise XFER.
- WAIT (cycles 2..WAIT_STATES+1):
  - CE_n=0; read: OE_n=0; write: WE_n=0.
  - cnt decrements each cycle; go to XFER when cnt==0.
- XFER (cycle WAIT_STATES+2):
  - CE_n=0. Read: OE_n=0, MDR<=Data_from_SRAM. Write: WE_n=0.
  - Go to DONE.
- DONE (cycle WAIT_STATES+3):
  - done=1 for exactly one cycle; all strobes=1; go to IDLE.
- Latency:
  - Request to done is WAIT_STATES+3 cycles (5 at default).
  - Next accept is earliest at cycle WAIT_STATES+4, i.e. one request every WAIT_STATES+4 cycles.
- Busy behaviour:
  - req_ready=0 outside IDLE. req_valid while busy is ignored, not queued.
  - MAR and MDR do not change outside IDLE accept and XFER capture.
- Invariants:
  - OE_n and WE_n are never low in the same cycle.
  - CE_n is low only in ADDR, WAIT and XFER.
- Address: no arithmetic on addr_in; the full 16-bit value is used, and 16'hFFFF is a legal SRAM address unless the optional feature is compiled in.

Optional Feature:
- Macro MEM_ACCESS_IO_MAP_EN.
- Defined:
  - Extra ports: Switches in 16 and HEX_reg out 16; HEX_reg resets to 0.
  - Accepted address 16'hFFFF goes IDLE->DONE directly with no SRAM strobes; done arrives in cycle 1.
  - Read: MDR<=Switches at accept.
  - Write: HEX_reg<=wdata_in, MDR<=wdata_in at accept.
- Not defined: extra ports are absent and 16'hFFFF is an ordinary SRAM access.

Decomposition:
- Package slc3_mem_pkg holds:
  - typedef enum logic [2:0] mem_state_t {IDLE, ADDR, WAIT, XFER, DONE}.
  - localparam IO_ADDR = 16'hFFFF.
  - Default WAIT_STATES and widths.
- The wait counter is a natural sub-module, wait_counter: load, decrement, zero flag, width $clog2(16).
- The FSM and the MAR/MDR registers stay in mem_access_unit.

Test Plan:
- Reset: hold Reset_n=0, then release -> req_ready=1, done=0, MAR=0, MDR=0, strobes all 1.
- Read: SRAM model mem[16'h3005]=16'hBEEF, read req addr 16'h3005 at cycle 0 -> CE_n/OE_n low cycles 1-4, MDR_out=16'hBEEF, done=1 in cycle 5 only.
- Write: write req addr 16'h4000, data 16'h1234 -> WE_n low cycles 2-4 only, never low with OE_n, mem[16'h4000]=16'h1234, done in cycle 5.
- Busy and WAIT_STATES=0: second req_valid asserted in cycles 1-5 is ignored, accepted once back in IDLE; with WAIT_STATES=0 a read completes with done in cycle 3.
- Reset mid-access: Reset_n low in cycle 3 of a read -> strobes high at once, state IDLE, MDR keeps 0 (no capture).
- IO map (macro defined): Switches=16'h00A5, read 16'hFFFF -> MDR=16'h00A5, done in cycle 1, no strobes; write 16'hFFFF with 16'h0042 -> HEX_reg=16'h0042.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared types and defaults for the SLC-3 memory access stage.
// Latency: none; this file holds declarations only.
// Backpressure: none; this file holds declarations only.
package slc3_mem_pkg;

    localparam int ADDR_W_DEF      = 16;
    localparam int DATA_W_DEF      = 16;
    localparam int WAIT_STATES_DEF = 2;
    // Counter covers the full legal wait-state range 0..15.
    localparam int CNT_W           = $clog2(16);

    // Memory-mapped I/O location (switches / hex display).
    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        XFER,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_access_unit_wait_counter.sv
// Down-counter that paces the SRAM wait states.
// Latency: load or decrement takes effect on the next rising edge.
// Backpressure: none; the counter stops at zero and holds until reloaded.
module wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load has priority over decrement; never wrap below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// SLC-3 memory stage: latches address in MAR, runs one SRAM access, returns data in MDR.
// Latency: request to done is WAIT_STATES+3 cycles; one request every WAIT_STATES+4 cycles.
// Backpressure: req_ready is high only in IDLE; req_valid while busy is dropped, not queued.
// Optional I/O map at 16'hFFFF (Switches / HEX_reg) is built when MEM_ACCESS_IO_MAP_EN is defined.
module mem_access_unit
    import slc3_mem_pkg::*;
#(
    parameter int WAIT_STATES = WAIT_STATES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              req_ready,
    output logic              done,
    output logic [ADDR_W-1:0] MAR_out,
    output logic [DATA_W-1:0] MDR_out,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              MEM_CE_n,
    output logic              MEM_OE_n,
    output logic              MEM_WE_n
`ifdef MEM_ACCESS_IO_MAP_EN
    ,
    input  logic [15:0]       Switches,
    output logic [15:0]       HEX_reg
`endif
);

    // Value loaded in ADDR; unused when there are no wait states.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              wr_q, wr_d;
    logic              accept;
    logic              cnt_zero;
    logic              busy_sram;

    assign accept = req_valid && (state_q == IDLE);

`ifdef MEM_ACCESS_IO_MAP_EN
    logic        io_hit;
    logic [15:0] hex_q, hex_d;
    assign io_hit  = (addr_in == ADDR_W'(IO_ADDR));
    assign HEX_reg = hex_q;
`endif

    wait_counter #(
        .CNT_W(CNT_W)
    ) u_wait_counter (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .load_i     (state_q == ADDR),
        .load_val_i (CNT_LOAD),
        .dec_i      (state_q == WAIT),
        .zero_o     (cnt_zero)
    );

    // State register; reset aborts any access in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: fixed walk ADDR -> WAIT* -> XFER -> DONE, I/O hits jump to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = ADDR;
`ifdef MEM_ACCESS_IO_MAP_EN
                    if (io_hit) state_d = DONE;
`endif
                end
            end
            ADDR:    state_d = (WAIT_STATES > 0) ? WAIT : XFER;
            WAIT:    if (cnt_zero) state_d = XFER;
            XFER:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from state only, so reset releases the strobes immediately.
    always_comb begin
        busy_sram = (state_q == ADDR) || (state_q == WAIT) || (state_q == XFER);
        req_ready = (state_q == IDLE);
        done      = (state_q == DONE);
        MEM_CE_n  = !busy_sram;
        MEM_OE_n  = !(busy_sram && !wr_q);
        // Write enable waits one cycle after CE for address setup.
        MEM_WE_n  = !(wr_q && ((state_q == WAIT) || (state_q == XFER)));
    end

    // MAR/MDR only move on accept and on read capture in XFER.
    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        wr_d  = wr_q;
`ifdef MEM_ACCESS_IO_MAP_EN
        hex_d = hex_q;
`endif
        if (accept) begin
            mar_d = addr_in;
            wr_d  = req_write;
            if (req_write) begin
                mdr_d = wdata_in;
            end
`ifdef MEM_ACCESS_IO_MAP_EN
            if (io_hit) begin
                if (req_write) hex_d = wdata_in;
                else           mdr_d = DATA_W'(Switches);
            end
`endif
        end
        if ((state_q == XFER) && !wr_q) begin
            mdr_d = Data_from_SRAM;
        end
    end

    // Datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mar_q <= '0;
            mdr_q <= '0;
            wr_q  <= 1'b0;
`ifdef MEM_ACCESS_IO_MAP_EN
            hex_q <= '0;
`endif
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            wr_q  <= wr_d;
`ifdef MEM_ACCESS_IO_MAP_EN
            hex_q <= hex_d;
`endif
        end
    end

    assign MAR_out      = mar_q;
    assign MDR_out      = mdr_q;
    assign MEM_ADDR     = mar_q;
    assign Data_to_SRAM = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: default (2 wait states) and zero-wait-state instances sharing one SRAM model.
// Latency: expected done cycle and MDR are queued at request time and popped on done.
// Backpressure: busy-time requests are held high to show they are ignored until IDLE.
module tb_mem_access_unit;

    logic        Clk;
    logic        Reset_n;
    logic        req_valid, req_write;
    logic [15:0] addr_in, wdata_in;
    logic        sel;  // 0: WAIT_STATES=2 unit, 1: WAIT_STATES=0 unit
    logic [15:0] Switches;

    logic        rdy_a, done_a, ce_a, oe_a, we_a;
    logic [15:0] mar_a, mdr_a, ma_a, dto_a, dfrom_a;
    logic        rdy_b, done_b, ce_b, oe_b, we_b;
    logic [15:0] mar_b, mdr_b, ma_b, dto_b, dfrom_b;
`ifdef MEM_ACCESS_IO_MAP_EN
    logic [15:0] hex_a, hex_b;
`endif

    logic [15:0] mem [0:65535];
    logic        pl_en;
    logic [15:0] pl_addr, pl_dat;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          cyc;
        logic [15:0] mdr;
    } exp_t;
    exp_t sb[$];

    mem_access_unit u_dut_a (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid && !sel), .req_write(req_write),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .req_ready(rdy_a), .done(done_a), .MAR_out(mar_a), .MDR_out(mdr_a),
        .MEM_ADDR(ma_a), .Data_to_SRAM(dto_a), .Data_from_SRAM(dfrom_a),
        .MEM_CE_n(ce_a), .MEM_OE_n(oe_a), .MEM_WE_n(we_a)
`ifdef MEM_ACCESS_IO_MAP_EN
        , .Switches(Switches), .HEX_reg(hex_a)
`endif
    );

    mem_access_unit #(.WAIT_STATES(0)) u_dut_b (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid && sel), .req_write(req_write),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .req_ready(rdy_b), .done(done_b), .MAR_out(mar_b), .MDR_out(mdr_b),
        .MEM_ADDR(ma_b), .Data_to_SRAM(dto_b), .Data_from_SRAM(dfrom_b),
        .MEM_CE_n(ce_b), .MEM_OE_n(oe_b), .MEM_WE_n(we_b)
`ifdef MEM_ACCESS_IO_MAP_EN
        , .Switches(Switches), .HEX_reg(hex_b)
`endif
    );

    // Asynchronous-read SRAM model shared by both units.
    assign dfrom_a = mem[ma_a];
    assign dfrom_b = mem[ma_b];

    always @(posedge Clk) begin
        if (pl_en)        mem[pl_addr] <= pl_dat;
        if (!ce_a && !we_a) mem[ma_a]  <= dto_a;
        if (!ce_b && !we_b) mem[ma_b]  <= dto_b;
    end

    wire        obs_ready = sel ? rdy_b  : rdy_a;
    wire        obs_done  = sel ? done_b : done_a;
    wire        obs_ce    = sel ? ce_b   : ce_a;
    wire        obs_oe    = sel ? oe_b   : oe_a;
    wire        obs_we    = sel ? we_b   : we_a;
    wire [15:0] obs_mar   = sel ? mar_b  : mar_a;
    wire [15:0] obs_mdr   = sel ? mdr_b  : mdr_a;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobes {CE_n, OE_n, WE_n} expected in cycle k after accept.
    function automatic logic [2:0] exp_strobes(input bit wr, input int k, input int ws, input bit io);
        logic ce, oe, we;
        ce = 1'b1; oe = 1'b1; we = 1'b1;
        if (!io && k >= 1 && k <= ws + 2) begin
            ce = 1'b0;
            if (!wr)        oe = 1'b0;
            else if (k >= 2) we = 1'b0;
        end
        return {ce, oe, we};
    endfunction

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_dat = d;
        @(negedge Clk);
        pl_en = 1'b0;
    endtask

    // Called at a negedge (cycle 0). With hold, req_valid stays high and addr moves to addr+1.
    task automatic run_access(input string tag, input logic wr, input logic [15:0] addr,
                              input logic [15:0] data, input logic [15:0] exp_mdr,
                              input bit hold, input bit io);
        int   ws;
        bit   got;
        exp_t e;
        ws = sel ? 0 : 2;
        req_write = wr; addr_in = addr; wdata_in = data; req_valid = 1'b1;
        check({tag, "_ready_c0"}, 32'(obs_ready), 32'd1);
        e.cyc = io ? 1 : ws + 3;
        e.mdr = exp_mdr;
        sb.push_back(e);
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                if (hold) addr_in = addr + 16'h1;
                else      req_valid = 1'b0;
            end
            check({tag, "_strobes"}, 32'({obs_ce, obs_oe, obs_we}), 32'(exp_strobes(wr, k, ws, io)));
            check({tag, "_oe_we_excl"}, 32'(obs_oe | obs_we), 32'd1);
            check({tag, "_mar"}, 32'(obs_mar), 32'(addr));
            if (k >= 1 && !obs_done) check({tag, "_busy_rdy"}, 32'(obs_ready), 32'd0);
            if (obs_done) begin
                e = sb.pop_front();
                check({tag, "_done_cycle"}, 32'(k), 32'(e.cyc));
                check({tag, "_mdr"}, 32'(obs_mdr), 32'(e.mdr));
                got = 1'b1;
            end
        end
        if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
        if (!hold) begin
            @(negedge Clk);
            check({tag, "_done_pulse"}, 32'(obs_done), 32'd0);
            check({tag, "_ready_after"}, 32'(obs_ready), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        addr_in = '0; wdata_in = '0; sel = 1'b0; Switches = 16'h00A5;
        pl_en = 1'b0; pl_addr = '0; pl_dat = '0;

        @(negedge Clk);
        preload(16'h3005, 16'hBEEF);
        preload(16'h3006, 16'h5A5A);
        preload(16'h4000, 16'h0000);

        // Reset state
        check("rst_ready", 32'(rdy_a), 32'd1);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_mar", 32'(mar_a), 32'd0);
        check("rst_mdr", 32'(mdr_a), 32'd0);
        check("rst_strobes", 32'({ce_a, oe_a, we_a}), 32'd7);
        check("rst_ready_b", 32'(rdy_b), 32'd1);
`ifdef MEM_ACCESS_IO_MAP_EN
        check("rst_hex", 32'(hex_a), 32'd0);
`endif
        Reset_n = 1'b1;
        @(negedge Clk);
        check("post_rst_ready", 32'(rdy_a), 32'd1);

        // Reset in cycle 3 of a read: strobes drop at once, no MDR capture.
        req_write = 1'b0; addr_in = 16'h3005; req_valid = 1'b1;
        @(negedge Clk);
        req_valid = 1'b0;
        check("abort_ce_c1", 32'(ce_a), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("abort_strobes", 32'({ce_a, oe_a, we_a}), 32'd7);
        check("abort_ready", 32'(rdy_a), 32'd1);
        check("abort_mdr", 32'(mdr_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("abort_idle", 32'(rdy_a), 32'd1);
        check("abort_mdr_after", 32'(mdr_a), 32'd0);

        // Read and write with two wait states.
        run_access("read", 1'b0, 16'h3005, 16'h0000, 16'hBEEF, 1'b0, 1'b0);
        run_access("write", 1'b1, 16'h4000, 16'h1234, 16'h1234, 1'b0, 1'b0);
        check("write_mem", 32'(mem[16'h4000]), 32'h1234);

        // Request held through the busy window is taken only once back in IDLE.
        run_access("busy1", 1'b0, 16'h3005, 16'h0000, 16'hBEEF, 1'b1, 1'b0);
        @(negedge Clk);
        run_access("busy2", 1'b0, 16'h3006, 16'h0000, 16'h5A5A, 1'b0, 1'b0);

        // Zero wait states.
        sel = 1'b1;
        run_access("ws0_read", 1'b0, 16'h4000, 16'h0000, 16'h1234, 1'b0, 1'b0);
        run_access("ws0_write", 1'b1, 16'h0010, 16'hCAFE, 16'hCAFE, 1'b0, 1'b0);
        check("ws0_write_mem", 32'(mem[16'h0010]), 32'hCAFE);
        run_access("ws0_ffff", 1'b1, 16'hFFFF, 16'h7777, 16'h7777, 1'b0,
`ifdef MEM_ACCESS_IO_MAP_EN
                   1'b1);
`else
                   1'b0);
        check("ffff_sram_mem", 32'(mem[16'hFFFF]), 32'h7777);
`endif
        sel = 1'b0;

`ifdef MEM_ACCESS_IO_MAP_EN
        run_access("io_read", 1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 1'b0, 1'b1);
        run_access("io_write", 1'b1, 16'hFFFF, 16'h0042, 16'h0042, 1'b0, 1'b1);
        check("io_hex", 32'(hex_a), 32'h0042);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
